// File: rtl/fifo_flex.sv
// fifo_flex: single-clock FIFO with standard or first-word-fall-through read, level flags and error pulses
//   clk, rst             clock (rising edge), asynchronous active-high reset
//   write, din           push request and write data
//   read, dout           read request (standard) / pop acknowledge (FWFT), read data
//   full, empty          count == DEPTH / no readable word
//   afull, aempty        count >= AFULL_TH / count <= AEMPTY_TH
//   count                words held, including the FWFT head word
//   overflow, underflow  one-cycle pulses after a rejected write / read
module fifo_flex #(
    parameter int DWIDTH    = 32,
    parameter int AWIDTH    = 4,
    parameter int FWFT      = 0,
    parameter int AFULL_TH  = 2**AWIDTH-2,
    parameter int AEMPTY_TH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              write,
    input  logic              read,
    input  logic [DWIDTH-1:0] din,
    output logic [DWIDTH-1:0] dout,
    output logic              full,
    output logic              empty,
    output logic              afull,
    output logic              aempty,
    output logic [AWIDTH:0]   count,
    output logic              overflow,
    output logic              underflow
);
    localparam logic [AWIDTH:0] DEPTH_C = {1'b1, {AWIDTH{1'b0}}};
    localparam logic [AWIDTH:0] AF_C    = (AWIDTH+1)'(AFULL_TH);
    localparam logic [AWIDTH:0] AE_C    = (AWIDTH+1)'(AEMPTY_TH);
    logic [DWIDTH-1:0] mem_q [2**AWIDTH];
    logic [AWIDTH:0]   wptr_q, wptr_d, rptr_q, rptr_d, count_q, count_d;
    logic [DWIDTH-1:0] dout_q, dout_d;
    logic              hv_q, hv_d, ovf_q, ovf_d, unf_q, unf_d;
    logic              wen, ren, pop;
    // pop moves a word out of memory into dout_q: on every accepted read in
    // standard mode, or whenever the FWFT head is free/being freed and memory
    // still holds words (a same-edge write is not yet visible to the head).
    always_comb begin
        wen     = write & ~full;
        ren     = read & ~empty;
        pop     = (FWFT != 0) ? (~hv_q | ren) & (wptr_q != rptr_q) : ren;
        wptr_d  = wptr_q + (AWIDTH+1)'(wen);
        rptr_d  = rptr_q + (AWIDTH+1)'(pop);
        count_d = count_q + (AWIDTH+1)'(wen) - (AWIDTH+1)'(ren);
        dout_d  = pop ? mem_q[rptr_q[AWIDTH-1:0]] : dout_q;
        hv_d    = pop | (hv_q & ~ren);
        ovf_d   = write & full;
        unf_d   = read & empty;
    end
    always_ff @(posedge clk) begin
        if (wen) mem_q[wptr_q[AWIDTH-1:0]] <= din;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            dout_q  <= '0;
            hv_q    <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            dout_q  <= dout_d;
            hv_q    <= hv_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end
    assign full      = count_q == DEPTH_C;
    assign empty     = (FWFT != 0) ? ~hv_q : count_q == '0;
    assign afull     = count_q >= AF_C;
    assign aempty    = count_q <= AE_C;
    assign count     = count_q;
    assign dout      = dout_q;
    assign overflow  = ovf_q;
    assign underflow = unf_q;
endmodule

// File: tb/tb_fifo_flex.sv
// tb_fifo_flex: drives a standard and a FWFT instance with shared stimulus and checks both against queue models
module tb_fifo_flex;
    localparam int DW = 8, AW = 2, DEPTH = 4, AF = 3, AE = 1;
    logic          clk = 0, rst = 0, write = 0, read = 0;
    logic [DW-1:0] din = 0;
    logic [DW-1:0] dout [2];
    logic [AW:0]   count [2];
    logic          full [2], empty [2], afull [2], aempty [2], ovf [2], unf [2];
    int            checks = 0, errors = 0;
    logic [DW-1:0] qs [$];
    logic [DW-1:0] qf [$];
    logic [DW-1:0] ds = 0;
    bit            hv = 0, ws, wf, rf;
    bit            ov [2] = '{0, 0};
    bit            un [2] = '{0, 0};
    int            inmem, pw, pr;

    fifo_flex #(.DWIDTH(DW), .AWIDTH(AW), .FWFT(0), .AFULL_TH(AF), .AEMPTY_TH(AE)) u_std (
        .clk(clk), .rst(rst), .write(write), .read(read), .din(din), .dout(dout[0]),
        .full(full[0]), .empty(empty[0]), .afull(afull[0]), .aempty(aempty[0]),
        .count(count[0]), .overflow(ovf[0]), .underflow(unf[0]));
    fifo_flex #(.DWIDTH(DW), .AWIDTH(AW), .FWFT(1), .AFULL_TH(AF), .AEMPTY_TH(AE)) u_fwft (
        .clk(clk), .rst(rst), .write(write), .read(read), .din(din), .dout(dout[1]),
        .full(full[1]), .empty(empty[1]), .afull(afull[1]), .aempty(aempty[1]),
        .count(count[1]), .overflow(ovf[1]), .underflow(unf[1]));

    always #5 clk = ~clk;

    task automatic chk(input string n, input int a, input int e);
        checks++;
        if (a != e) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", n, a, e);
        end
    endtask

    // Reference: standard mode is a plain queue whose popped word becomes dout;
    // FWFT keeps every word in the queue and tracks whether the front is visible.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            qs.delete();
            qf.delete();
            ds = 0;
            hv = 0;
            ov = '{0, 0};
            un = '{0, 0};
        end else begin
            ov[0] = write && qs.size() == DEPTH;
            un[0] = read && qs.size() == 0;
            ws = write && qs.size() != DEPTH;
            if (read && qs.size() != 0) ds = qs.pop_front();
            if (ws) qs.push_back(din);
            ov[1] = write && qf.size() == DEPTH;
            un[1] = read && !hv;
            wf = write && qf.size() != DEPTH;
            rf = read && hv;
            inmem = qf.size() - (hv ? 1 : 0);
            if (rf) void'(qf.pop_front());
            if ((!hv || rf) && inmem > 0) hv = 1;
            else if (rf) hv = 0;
            if (wf) qf.push_back(din);
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("s_count", count[0], qs.size());
            chk("s_full", full[0], qs.size() == DEPTH);
            chk("s_empty", empty[0], qs.size() == 0);
            chk("s_afull", afull[0], qs.size() >= AF);
            chk("s_aempty", aempty[0], qs.size() <= AE);
            chk("s_overflow", ovf[0], ov[0]);
            chk("s_underflow", unf[0], un[0]);
            chk("s_dout", dout[0], ds);
            chk("f_count", count[1], qf.size());
            chk("f_full", full[1], qf.size() == DEPTH);
            chk("f_empty", empty[1], !hv);
            chk("f_afull", afull[1], qf.size() >= AF);
            chk("f_aempty", aempty[1], qf.size() <= AE);
            chk("f_overflow", ovf[1], ov[1]);
            chk("f_underflow", unf[1], un[1]);
            if (hv) chk("f_dout", dout[1], qf[0]);
        end
    end

    task automatic tick(input bit w, input bit r, input logic [DW-1:0] d);
        @(negedge clk);
        write = w;
        read = r;
        din = d;
        @(posedge clk);
        #1;
    endtask

    task automatic rst_pulse();
        #1 rst = 1;
        #1 rst = 0;
    endtask

    initial begin
        #1 rst = 1;
        #1;
        chk("rst_count", count[0], 0);
        chk("rst_empty", empty[0], 1);
        chk("rst_full", full[0], 0);
        chk("rst_afull", afull[0], 0);
        chk("rst_aempty", aempty[0], 1);
        chk("rst_dout", dout[0], 0);
        chk("rst_flags", {ovf[0], unf[0], ovf[1], unf[1]}, 0);
        chk("rst_f_empty", empty[1], 1);
        @(negedge clk) rst = 0;
        tick(1, 0, 8'h11);
        chk("lit_cnt1", count[0], 1);
        chk("lit_f_empty_n", empty[1], 1);
        tick(1, 0, 8'h22);
        chk("lit_cnt2", count[0], 2);
        chk("lit_f_head", dout[1], 8'h11);
        chk("lit_f_vis", empty[1], 0);
        tick(1, 0, 8'h33);
        chk("lit_afull3", afull[0], 1);
        chk("lit_nfull3", full[0], 0);
        tick(1, 0, 8'h44);
        chk("lit_full4", full[0], 1);
        tick(1, 1, 8'h55);
        chk("lit_ovf_cnt", count[0], 3);
        chk("lit_ovf", ovf[0], 1);
        chk("lit_rd11", dout[0], 8'h11);
        chk("lit_f_pop", dout[1], 8'h22);
        tick(0, 1, 0);
        chk("lit_rd22", dout[0], 8'h22);
        chk("lit_ovf_gone", ovf[0], 0);
        tick(0, 1, 0);
        chk("lit_rd33", dout[0], 8'h33);
        tick(0, 1, 0);
        chk("lit_rd44", dout[0], 8'h44);
        chk("lit_empty_end", empty[0], 1);
        tick(1, 1, 8'h66);
        chk("lit_unf", unf[0], 1);
        chk("lit_unf_cnt", count[0], 1);
        tick(0, 1, 0);
        chk("lit_rd66", dout[0], 8'h66);
        chk("lit_unf_gone", unf[0], 0);
        rst_pulse();
        tick(1, 0, 8'hA5);
        chk("lit_fa5_empty", empty[1], 1);
        tick(1, 0, 8'h5A);
        chk("lit_fa5", dout[1], 8'hA5);
        chk("lit_fcnt2", count[1], 2);
        tick(0, 1, 0);
        chk("lit_f5a", dout[1], 8'h5A);
        chk("lit_fcnt1", count[1], 1);
        tick(0, 1, 0);
        chk("lit_fcnt0", count[1], 0);
        chk("lit_f_empty", empty[1], 1);
        rst_pulse();
        for (int i = 1; i <= 3; i++) tick(1, 0, DW'(i));
        for (int i = 0; i < 10; i++) begin
            tick(1, 1, DW'(4 + i));
            chk("wrap_s", dout[0], i + 1);
            chk("wrap_f", dout[1], i + 2);
            chk("wrap_cnt", count[0], 3);
        end
        rst_pulse();
        tick(1, 0, 8'h11);
        tick(1, 0, 8'h22);
        #1 rst = 1;
        #1;
        chk("arst_count", count[0], 0);
        chk("arst_empty", empty[0], 1);
        chk("arst_dout", dout[0], 0);
        chk("arst_f_count", count[1], 0);
        chk("arst_f_empty", empty[1], 1);
        rst = 0;
        tick(1, 0, 8'h77);
        tick(0, 1, 0);
        chk("arst_rd77", dout[0], 8'h77);
        chk("arst_f77", dout[1], 8'h77);
        for (int i = 0; i < 3000; i++) begin
            if (i % 300 == 0) begin
                pw = 20 + 30 * int'($urandom_range(0, 2));
                pr = 20 + 30 * int'($urandom_range(0, 2));
            end
            tick($urandom_range(0, 99) < pw, $urandom_range(0, 99) < pr, DW'($urandom));
            if ($urandom_range(0, 399) == 0) rst_pulse();
        end
        tick(0, 0, 0);
        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
